core_wb_arbiter: RTL and testbench

Write-side front end of the core register file. It collects results from NCH functional-unit channels (ALU, load unit, mul/div, ...) over valid/ready handshakes. It grants one result per cycle, round-robin, and drives the register file's single write port (waddr/wdata/wen) from a registered stage. It also keeps a per-register pending scoreboard so decode can detect RAW/WAW hazards against in-flight writes.

---
 rtl/core_wb_arbiter_if.sv | 36 +++
 rtl/core_wb_arbiter.sv | 105 ++++++++++
 tb/tb_core_wb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_wb_arbiter_if.sv
// Bundles the result channels, the register-file write port and the decode
// scoreboard queries of core_wb_arbiter.
// slave = arbiter side, master = functional units / decode / register file side.
interface core_wb_arbiter_if #(
  parameter int NCH  = 3,
  parameter int XLEN = 32
);
  logic [NCH-1:0]      req_valid;
  logic [5*NCH-1:0]    req_rd;
  logic [XLEN*NCH-1:0] req_data;
  logic [NCH-1:0]      req_ready;
  logic [4:0]          waddr;
  logic [XLEN-1:0]     wdata;
  logic                wen;
  logic                iss_valid;
  logic [4:0]          iss_rd;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                rd_busy;
  logic                rs1_fwd;
  logic                rs2_fwd;

  modport slave (
    input  req_valid, req_rd, req_data, iss_valid, iss_rd, rs1, rs2,
    output req_ready, waddr, wdata, wen, rs1_busy, rs2_busy, rd_busy,
           rs1_fwd, rs2_fwd
  );

  modport master (
    output req_valid, req_rd, req_data, iss_valid, iss_rd, rs1, rs2,
    input  req_ready, waddr, wdata, wen, rs1_busy, rs2_busy, rd_busy,
           rs1_fwd, rs2_fwd
  );
endinterface

// File: rtl/core_wb_arbiter.sv
// Register-file write-side front end: round-robin grant of one result per
// cycle from NCH channels, registered write port, and a pending-write
// scoreboard for decode hazard checks.
// Optional macro WB_BYPASS_EN: report forwarding hits on the write in
// flight and mask the matching busy flag.
module core_wb_arbiter #(
  parameter int NCH  = 3,
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  core_wb_arbiter_if.slave bus
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;
  logic            wen_q;
  logic [31:0]     sb_q, sb_d;

  logic            found_c;
  logic [PW-1:0]   gidx_c;
  logic [4:0]      sel_rd_c;
  logic [XLEN-1:0] sel_data_c;
  logic [NCH-1:0]  grant_c;

  // Round-robin search starting at ptr_q, wrapping modulo NCH
  always_comb begin
    found_c = 1'b0;
    gidx_c  = ptr_q;
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      if (!found_c && bus.req_valid[j]) begin
        found_c = 1'b1;
        gidx_c  = PW'(j);
      end
    end
    grant_c = '0;
    if (found_c && rst) grant_c[gidx_c] = 1'b1;
    sel_rd_c   = bus.req_rd[int'(gidx_c)*5 +: 5];
    sel_data_c = bus.req_data[int'(gidx_c)*XLEN +: XLEN];
    if (gidx_c == PW'(NCH - 1)) ptr_d = '0;
    else                        ptr_d = gidx_c + PW'(1);
  end

  assign bus.req_ready = grant_c;

  // Scoreboard next state: the committing write clears first so a same-edge issue wins
  always_comb begin
    sb_d = sb_q;
    if (wen_q) sb_d[waddr_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) sb_d[bus.iss_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Write-port register, round-robin pointer and scoreboard state
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      sb_q    <= '0;
    end else begin
      sb_q <= sb_d;
      if (found_c) begin
        waddr_q <= sel_rd_c;
        wdata_q <= sel_data_c;
        wen_q   <= (sel_rd_c != 5'd0);
        ptr_q   <= ptr_d;
      end else begin
        wen_q <= 1'b0;
      end
    end
  end

  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.wen   = wen_q;

  logic rs1_pend_c, rs2_pend_c;
  assign rs1_pend_c  = (bus.rs1 != 5'd0) && sb_q[bus.rs1];
  assign rs2_pend_c  = (bus.rs2 != 5'd0) && sb_q[bus.rs2];
  assign bus.rd_busy = (bus.iss_rd != 5'd0) && sb_q[bus.iss_rd];

`ifdef WB_BYPASS_EN
  logic rs1_fwd_c, rs2_fwd_c;
  assign rs1_fwd_c    = wen_q && (waddr_q == bus.rs1) && (bus.rs1 != 5'd0);
  assign rs2_fwd_c    = wen_q && (waddr_q == bus.rs2) && (bus.rs2 != 5'd0);
  assign bus.rs1_fwd  = rs1_fwd_c;
  assign bus.rs2_fwd  = rs2_fwd_c;
  assign bus.rs1_busy = rs1_pend_c && !rs1_fwd_c;
  assign bus.rs2_busy = rs2_pend_c && !rs2_fwd_c;
`else
  assign bus.rs1_fwd  = 1'b0;
  assign bus.rs2_fwd  = 1'b0;
  assign bus.rs1_busy = rs1_pend_c;
  assign bus.rs2_busy = rs2_pend_c;
`endif

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Bench for core_wb_arbiter (NCH=3): a vector table, hand sequences for the
// multi-cycle corner cases, and a randomized phase against a reference model.
module tb_core_wb_arbiter;
  localparam int NCH  = 3;
  localparam int XLEN = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_wb_arbiter_if #(.NCH(NCH), .XLEN(XLEN)) bus ();

  core_wb_arbiter #(.NCH(NCH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        rst_n;
    bit [2:0]  vld;
    bit [14:0] rd;
    bit        iss_v;
    bit [4:0]  iss_rd;
    bit [4:0]  rs1;
    bit [2:0]  e_ready;
    bit        e_wen;
    bit [4:0]  e_waddr;
    bit        e_busy;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [31:0] tdata(input int ch, input logic [4:0] rd);
    return {16'hC0DE, 8'(ch), 3'b000, rd};
  endfunction

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
  endtask

  task automatic set_ch(input int ch, input logic [4:0] rd, input logic [31:0] d);
    bus.req_valid[ch]          = 1'b1;
    bus.req_rd[ch*5 +: 5]      = rd;
    bus.req_data[ch*XLEN +: XLEN] = d;
  endtask

  // Reference model
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_ptr;
  bit          m_pend[32];
  bit          h_v[NCH];
  logic [4:0]  h_rd[NCH];
  logic [31:0] h_data[NCH];

  function automatic int exp_grant(input int p);
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = (p + k) % NCH;
      if (h_v[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    bit b;
    b = (r != 0) && m_pend[r];
    if (BYP && m_wen && (m_waddr == r)) b = 1'b0;
    return b;
  endfunction

  function automatic bit m_fwd(input logic [4:0] r);
    return BYP && m_wen && (m_waddr == r) && (r != 0);
  endfunction

  task automatic model_reset();
    m_wen = 0; m_waddr = 0; m_wdata = 0; m_ptr = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    // Table: each row is one cycle; expectations are what is visible during that cycle
    tbl[0]  = '{1, 3'b000, 15'd0, 1, 5'd5, 5'd5, 3'b000, 0, 5'd0, 0};
    tbl[1]  = '{1, 3'b000, 15'd0, 0, 5'd0, 5'd5, 3'b000, 0, 5'd0, 1};
    tbl[2]  = '{1, 3'b111, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 5'd5, 3'b001, 0, 5'd0, 1};
    tbl[3]  = '{1, 3'b111, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 5'd5, 3'b010, 1, 5'd1, 1};
    tbl[4]  = '{1, 3'b111, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 5'd5, 3'b100, 1, 5'd2, 1};
    tbl[5]  = '{1, 3'b111, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 5'd5, 3'b001, 1, 5'd3, 1};
    tbl[6]  = '{1, 3'b111, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 5'd5, 3'b010, 1, 5'd1, 1};
    tbl[7]  = '{1, 3'b111, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 5'd5, 3'b100, 1, 5'd2, 1};
    tbl[8]  = '{1, 3'b000, 15'd0, 0, 5'd0, 5'd5, 3'b000, 1, 5'd3, 1};
    tbl[9]  = '{1, 3'b001, 15'd0, 0, 5'd0, 5'd5, 3'b001, 0, 5'd3, 1};
    tbl[10] = '{1, 3'b000, 15'd0, 0, 5'd0, 5'd5, 3'b000, 0, 5'd0, 1};
    tbl[11] = '{1, 3'b111, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 5'd5, 3'b010, 0, 5'd0, 1};
    tbl[12] = '{1, 3'b000, 15'd0, 0, 5'd0, 5'd5, 3'b000, 1, 5'd2, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_wen", bus.wen, 0);
    chk("reset_ready", bus.req_ready, 0);
    chk("reset_rs1_busy", bus.rs1_busy, 0);

    for (int r = 0; r < 13; r++) begin
      drive_idle();
      rst = tbl[r].rst_n;
      for (int c = 0; c < NCH; c++)
        if (tbl[r].vld[c]) set_ch(c, tbl[r].rd[c*5 +: 5], tdata(c, tbl[r].rd[c*5 +: 5]));
      bus.iss_valid = tbl[r].iss_v;
      bus.iss_rd    = tbl[r].iss_rd;
      bus.rs1       = tbl[r].rs1;
      #1;
      chk($sformatf("tbl%0d_ready", r), bus.req_ready, tbl[r].e_ready);
      chk($sformatf("tbl%0d_wen", r), bus.wen, tbl[r].e_wen);
      chk($sformatf("tbl%0d_waddr", r), bus.waddr, tbl[r].e_waddr);
      chk($sformatf("tbl%0d_rs1_busy", r), bus.rs1_busy, tbl[r].e_busy);
      @(negedge clk);
    end

    // x5 pending; channel 1 delivers it (pointer is at 2, wraps to 1)
    drive_idle();
    set_ch(1, 5'd5, 32'hDEADBEEF);
    bus.rs1 = 5'd5;
    #1;
    chk("t2_ready", bus.req_ready, 3'b010);
    @(negedge clk);
    drive_idle();
    bus.rs1 = 5'd5;
    #1;
    chk("t2_wen", bus.wen, 1);
    chk("t2_waddr", bus.waddr, 5);
    chk("t2_wdata", bus.wdata, 32'hDEADBEEF);
    chk("t2_rs1_busy_wcycle", bus.rs1_busy, !BYP);
    chk("t2_rs1_fwd", bus.rs1_fwd, BYP);
    @(negedge clk);
    bus.rs1 = 5'd5;
    #1;
    chk("t2_wen_after", bus.wen, 0);
    chk("t2_rs1_busy_after", bus.rs1_busy, 0);
    @(negedge clk);

    // Same-edge set and clear of x7: set wins
    drive_idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
    #1;
    chk("t5_rd_busy_free", bus.rd_busy, 0);
    @(negedge clk);
    drive_idle();
    bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
    set_ch(0, 5'd7, 32'h77);
    #1;
    chk("t5_rd_busy_pend", bus.rd_busy, 1);
    chk("t5_rs1_busy_pend", bus.rs1_busy, 1);
    chk("t5_ready_wrap", bus.req_ready, 3'b001);
    @(negedge clk);
    drive_idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7; bus.rs1 = 5'd7;
    #1;
    chk("t5_wen", bus.wen, 1);
    chk("t5_waddr", bus.waddr, 7);
    @(negedge clk);
    drive_idle();
    bus.rs1 = 5'd7;
    #1;
    chk("t5_set_wins", bus.rs1_busy, 1);
    set_ch(0, 5'd7, 32'h78);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    bus.rs1 = 5'd7;
    #1;
    chk("t5_cleared", bus.rs1_busy, 0);
    @(negedge clk);

    // Reset mid-operation with x9 pending and a write in flight
    drive_idle();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    @(negedge clk);
    drive_idle();
    set_ch(2, 5'd9, 32'h99);
    @(negedge clk);
    drive_idle();
    bus.rs1 = 5'd9;
    for (int c = 0; c < NCH; c++) set_ch(c, 5'(c + 1), tdata(c, 5'(c + 1)));
    rst = 1'b0;
    #1;
    chk("t6_wen_before", bus.wen, 1);
    chk("t6_waddr_before", bus.waddr, 9);
    chk("t6_rs1_busy_before", bus.rs1_busy, !BYP);
    chk("t6_ready_in_reset", bus.req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_wen", bus.wen, 0);
    chk("t6_waddr", bus.waddr, 0);
    chk("t6_wdata", bus.wdata, 0);
    chk("t6_rs1_busy", bus.rs1_busy, 0);
    chk("t6_ptr0", bus.req_ready, 3'b001);
    @(negedge clk);

    // Randomized phase against the reference model
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < NCH; c++) h_v[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int g;
      bit iv;
      logic [4:0] ir;
      drive_idle();
      rst = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < NCH; c++) begin
        if (!h_v[c] && ($urandom_range(0, 1) == 1)) begin
          h_v[c]    = 1;
          h_rd[c]   = 5'($urandom_range(0, 31));
          h_data[c] = $urandom;
        end
        if (h_v[c]) set_ch(c, h_rd[c], h_data[c]);
      end
      ir = 5'($urandom_range(0, 31));
      iv = ($urandom_range(0, 2) == 0) && !((ir != 0) && m_pend[ir]);
      bus.iss_valid = iv;
      bus.iss_rd    = ir;
      bus.rs1       = 5'($urandom_range(0, 31));
      bus.rs2       = 5'($urandom_range(0, 31));
      #1;
      g = exp_grant(m_ptr);
      chk("rnd_ready", bus.req_ready, (rst && g >= 0) ? (3'b001 << g) : 3'b000);
      chk("rnd_wen", bus.wen, m_wen);
      chk("rnd_waddr", bus.waddr, m_waddr);
      chk("rnd_wdata", bus.wdata, m_wdata);
      chk("rnd_rs1_busy", bus.rs1_busy, m_busy(bus.rs1));
      chk("rnd_rs2_busy", bus.rs2_busy, m_busy(bus.rs2));
      chk("rnd_rd_busy", bus.rd_busy, (ir != 0) && m_pend[ir]);
      chk("rnd_rs1_fwd", bus.rs1_fwd, m_fwd(bus.rs1));
      chk("rnd_rs2_fwd", bus.rs2_fwd, m_fwd(bus.rs2));
      if (iv) chk("rnd_issue_legal", bus.rd_busy, 0);
      // Advance the model across the coming edge
      if (!rst) begin
        model_reset();
      end else begin
        if (m_wen) m_pend[m_waddr] = 0;
        if (iv && ir != 0) m_pend[ir] = 1;
        if (g >= 0) begin
          m_waddr = h_rd[g];
          m_wdata = h_data[g];
          m_wen   = (h_rd[g] != 0);
          m_ptr   = (g + 1) % NCH;
          h_v[g]  = 0;
        end else begin
          m_wen = 0;
        end
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
